seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clocks per digit slot; legal values >= 2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: clocks at the start of each slot with all anodes off; legal values 0..REFRESH_DIV-1.
REQ-003 SHALL have parameter BLINK_DIV, default 250: slot advances per blink half-period; legal values >= 1.
REQ-004 SHALL have port clk_c, input, 1 bit: clock.
REQ-005 SHALL have port reset_c, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports min_tens, min_ones, sec_tens, sec_ones, input, 4 bits each: BCD digits from the stopwatch counter.
REQ-007 SHALL have port adj, input, 1 bit: adjust mode active.
REQ-008 SHALL have port sel, input, 2 bits: digit under adjustment; 00 sec_ones, 01 sec_tens, 10 min_ones, 11 min_tens.
REQ-009 SHALL have port an, output, 4 bits: active-low anodes; an[0] sec_ones ... an[3] min_tens.
REQ-010 SHALL have port seg, output, 7 bits: active-low cathodes ordered {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 ref_cnt SHALL increment every clk and wrap from REFRESH_DIV-1 to 0; the wrap edge is slot_tick.
REQ-014 Scan index idx SHALL advance 0->1->2->3->0 on each slot_tick; idx n drives an[n].
REQ-015 On the slot_tick where idx wraps 3->0, all four inputs SHALL be captured into shadow registers and frame_tick SHALL be 1 for that single cycle.
REQ-016 Display SHALL use shadow values only; input changes mid-frame SHALL NOT appear until the next capture.
REQ-017 an, seg and dp SHALL be registered decodes of ref_cnt, idx, shadows and blink_phase, lagging that state by exactly 1 clk.
REQ-018 While ref_cnt < BLANK_CYCLES, an SHALL be 4'b1111, seg SHALL be 7'b1111111 and dp SHALL be 1.
REQ-019 Otherwise an SHALL be one-hot low at bit idx, and seg SHALL show the 7-seg code of the shadow digit for idx.
REQ-020 Digit codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 A shadow digit value of 10..15 SHALL display as a dash, 0111111.
REQ-022 dp SHALL be 0 only while idx=2 and not blanked, acting as the minutes/seconds separator; otherwise dp SHALL be 1.
REQ-023 blink_cnt SHALL count slot_ticks 0..BLINK_DIV-1 and toggle blink_phase on wrap, only while adj=1.
REQ-024 When adj=0, blink_cnt and blink_phase SHALL be cleared to 0 on the next clk.
REQ-025 When adj=1, blink_phase=1 and idx equals sel, that slot SHALL be fully blanked (an=1111, seg=1111111, dp=1); other slots SHALL be unaffected.
REQ-026 A sel change SHALL take effect at the next output register update, with no snapshot of sel.

Reset
REQ-027 Asserting reset_c SHALL immediately, without a clock, force: ref_cnt=0, idx=0, all shadows=0, blink_cnt=0, blink_phase=0, an=1111, seg=1111111, dp=1, frame_tick=0.
REQ-028 After reset release, the first frame SHALL display 00:00 from the cleared shadows, and the first capture SHALL occur at the first 3->0 wrap.
REQ-029 Reset asserted mid-slot or mid-blink SHALL abandon all partial counts; no residual state SHALL survive.

Verification
(Parameters for all scenarios: REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_DIV=2.)
REQ-030 Assert reset_c between clock edges mid-slot -> an=1111, seg=1111111, dp=1 before the next edge.
REQ-031 Inputs 12:34 held, after first capture -> per slot: 1 blank clk, then 3 clks each of an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100 with dp=0, an=0111/seg=1111001.
REQ-032 Change inputs from 12:34 to 56:78 while idx=1 -> remainder of the frame still shows 12:34; 56:78 appears in the frame after the next frame_tick.
REQ-033 sec_ones=4'hC -> seg=0111111 during slot 0; other digits correct.
REQ-034 adj=1, sel=10 -> an[2] never low for 2 consecutive slot advances out of every 4; slots 0, 1 and 3 unaffected; drop adj -> an[2] shown every frame from the next clk update.
REQ-035 Free run of 64 clks -> frame_tick high exactly once every 16 clks, each pulse 1 clk wide.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed 7-segment scan driver with frame capture and adjust blink
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 250
) (
    input  logic       clk_c,
    input  logic       reset_c,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       adj,
    input  logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [RW:0]   BLANK_END  = (RW + 1)'(BLANK_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [RW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic [3:0]    shadow [4];
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic          slot_tick;
    logic          blank;
    logic [3:0]    digit;
    logic [6:0]    code;

    assign slot_tick  = (ref_cnt == REF_LAST);
    assign frame_tick = slot_tick && (idx == 2'd3);

    // Guard band at the start of each slot plus the blink-off window of the digit being adjusted
    assign blank = ({1'b0, ref_cnt} < BLANK_END) || (adj && blink_phase && (idx == sel));
    assign digit = shadow[idx];

    always_comb begin
        code = 7'b0111111;
        case (digit)
            4'd0: code = 7'b1000000;
            4'd1: code = 7'b1111001;
            4'd2: code = 7'b0100100;
            4'd3: code = 7'b0110000;
            4'd4: code = 7'b0011001;
            4'd5: code = 7'b0010010;
            4'd6: code = 7'b0000010;
            4'd7: code = 7'b1111000;
            4'd8: code = 7'b0000000;
            4'd9: code = 7'b0010000;
            default: code = 7'b0111111;
        endcase
    end

    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            ref_cnt     <= '0;
            idx         <= 2'd0;
            shadow[0]   <= 4'd0;
            shadow[1]   <= 4'd0;
            shadow[2]   <= 4'd0;
            shadow[3]   <= 4'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
        end else begin
            ref_cnt <= slot_tick ? '0 : ref_cnt + 1'b1;

            if (slot_tick) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    shadow[0] <= sec_ones;
                    shadow[1] <= sec_tens;
                    shadow[2] <= min_ones;
                    shadow[3] <= min_tens;
                end
            end

            if (!adj) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (slot_tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            if (blank) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= code;
                dp  <= (idx != 2'd2);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam logic [6:0] C0   = 7'b1000000;
    localparam logic [6:0] C1   = 7'b1111001;
    localparam logic [6:0] C2   = 7'b0100100;
    localparam logic [6:0] C3   = 7'b0110000;
    localparam logic [6:0] C4   = 7'b0011001;
    localparam logic [6:0] C5   = 7'b0010010;
    localparam logic [6:0] C6   = 7'b0000010;
    localparam logic [6:0] C7   = 7'b1111000;
    localparam logic [6:0] C8   = 7'b0000000;
    localparam logic [6:0] DASH = 7'b0111111;

    logic       clk_c;
    logic       reset_c;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       adj;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int frame_no = 0;

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1),
        .BLINK_DIV   (2)
    ) dut (
        .clk_c     (clk_c),
        .reset_c   (reset_c),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .adj       (adj),
        .sel       (sel),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    initial begin
        clk_c = 1'b0;
        forever #5 clk_c = ~clk_c;
    end

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_an"},  {3'b000, an},         7'b0001111);
        chk({tag, "_seg"}, seg,                  7'b1111111);
        chk({tag, "_dp"},  {6'b0, dp},           7'd1);
        chk({tag, "_ft"},  {6'b0, frame_tick},   7'd0);
    endtask

    // One slot: guard clock then three digit clocks; blk[j] blanks sample j, adj drops after sample drop_after
    task automatic slot_check(input int s, input logic [6:0] code, input logic [3:0] blk, input int drop_after);
        logic       off;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic       ft_e;
        string      tag;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_c);
            off   = (j == 0) || blk[j];
            an_e  = off ? 4'b1111 : ~(4'b0001 << s);
            seg_e = off ? 7'b1111111 : code;
            dp_e  = off ? 1'b1 : (s != 2);
            ft_e  = (s == 3) && (j == 2);
            tag   = $sformatf("f%0d_s%0d_c%0d", frame_no, s, j);
            chk({tag, "_an"},  {3'b000, an},       {3'b000, an_e});
            chk({tag, "_seg"}, seg,                seg_e);
            chk({tag, "_dp"},  {6'b0, dp},         {6'b0, dp_e});
            chk({tag, "_ft"},  {6'b0, frame_tick}, {6'b0, ft_e});
            if (j == drop_after) adj = 1'b0;
        end
    endtask

    task automatic frame(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                         input logic [6:0] c3, input logic [3:0] blk2);
        slot_check(0, c0, 4'b0000, -1);
        slot_check(1, c1, 4'b0000, -1);
        slot_check(2, c2, blk2,    -1);
        slot_check(3, c3, 4'b0000, -1);
        frame_no++;
    endtask

    initial begin
        reset_c  = 1'b1;
        min_tens = 4'd1;
        min_ones = 4'd2;
        sec_tens = 4'd3;
        sec_ones = 4'd4;
        adj      = 1'b0;
        sel      = 2'd0;
        #1;
        chk_blank("reset_init");

        repeat (2) @(negedge clk_c);
        reset_c = 1'b0;

        // Cleared shadows show 00:00 until the first capture
        frame(C0, C0, C0, C0, 4'b0000);

        // 12:34 captured; inputs change while idx=1 and must not show this frame
        slot_check(0, C4, 4'b0000, -1);
        min_tens = 4'd5;
        min_ones = 4'd6;
        sec_tens = 4'd7;
        sec_ones = 4'd8;
        slot_check(1, C3, 4'b0000, -1);
        slot_check(2, C2, 4'b0000, -1);
        slot_check(3, C1, 4'b0000, -1);
        frame_no++;

        frame(C8, C7, C6, C5, 4'b0000);

        sec_ones = 4'hC;
        frame(C8, C7, C6, C5, 4'b0000);
        frame(DASH, C7, C6, C5, 4'b0000);

        // Adjust minutes-ones: blink phase lands on slot 2 in every frame here
        adj = 1'b1;
        sel = 2'd2;
        frame(DASH, C7, C6, C5, 4'b1111);

        slot_check(0, DASH, 4'b0000, -1);
        slot_check(1, C7,   4'b0000, -1);
        slot_check(2, C6,   4'b0011, 1);
        slot_check(3, C5,   4'b0000, -1);
        frame_no++;

        frame(DASH, C7, C6, C5, 4'b0000);

        // Asynchronous reset between edges while a digit is lit
        repeat (2) @(negedge clk_c);
        #2 reset_c = 1'b1;
        #1;
        chk_blank("reset_mid");
        @(negedge clk_c);
        chk_blank("reset_hold");
        reset_c = 1'b0;

        frame(C0, C0, C0, C0, 4'b0000);
        frame(DASH, C7, C6, C5, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
